// File: rtl/pulse_sequence_checker_fsm.sv
// Receive-side checker for the pulse sequencer's one-hot step bus: verifies step order
// and per-step durations, counts good sequences and keeps a sticky first-error record.
module pulse_sequence_checker_fsm #(
  parameter int NB_STATE     = 2,
  parameter int N_STEPS      = 5,
  parameter int LOG2_N_STEPS = 3,
  parameter int NB_TIMER     = 4,
  parameter int NB_SEQ_COUNT = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_valid,
  input  logic [N_STEPS-1:0]           i_pulse_bus,
  input  logic [N_STEPS*NB_TIMER-1:0]  i_limit_time_bus,
  input  logic                         i_clear,
  output logic                         o_done,
  output logic                         o_error,
  output logic [1:0]                   o_error_code,
  output logic [LOG2_N_STEPS-1:0]      o_error_step,
  output logic [NB_SEQ_COUNT-1:0]      o_seq_count,
  output logic [NB_STATE-1:0]          o_state
);

  localparam int NB_CNT = NB_TIMER + 1;

  localparam logic [NB_STATE-1:0] ST_IDLE    = NB_STATE'(0);
  localparam logic [NB_STATE-1:0] ST_MEASURE = NB_STATE'(1);
  localparam logic [NB_STATE-1:0] ST_ERROR   = NB_STATE'(2);
  localparam logic [NB_STATE-1:0] ST_ILLEGAL = NB_STATE'(3);

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_ORDER = 2'd1;
  localparam logic [1:0] CODE_SHORT = 2'd2;
  localparam logic [1:0] CODE_LONG  = 2'd3;

  logic [NB_STATE-1:0]     state_q, state_d;
  logic [LOG2_N_STEPS-1:0] step_q, step_d;
  logic [NB_CNT-1:0]       cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [1:0]              code_q, code_d;
  logic [LOG2_N_STEPS-1:0] err_step_q, err_step_d;
  logic [NB_SEQ_COUNT-1:0] seq_count_q, seq_count_d;

  // A programmed field of zero stands for the full 2**NB_TIMER cycles.
  logic [NB_CNT-1:0] limit_len [N_STEPS];

  for (genvar k = 0; k < N_STEPS; k++) begin : g_limit
    logic [NB_TIMER-1:0] field;
    assign field        = i_limit_time_bus[k*NB_TIMER +: NB_TIMER];
    assign limit_len[k] = (field == '0) ? {1'b1, {NB_TIMER{1'b0}}} : {1'b0, field};
  end

  logic [NB_CNT-1:0]  cur_len;
  logic [NB_CNT-1:0]  cnt_inc;
  logic [N_STEPS-1:0] onehot_first;
  logic [N_STEPS-1:0] onehot_cur;
  logic [N_STEPS-1:0] onehot_next;
  logic               step_last;
  logic               err_hit;
  logic [1:0]         err_hit_code;

  assign cur_len      = limit_len[step_q];
  assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + NB_CNT'(1);
  assign onehot_first = N_STEPS'(1);
  assign onehot_cur   = N_STEPS'(1) << step_q;
  assign onehot_next  = onehot_cur << 1;
  assign step_last    = (step_q == LOG2_N_STEPS'(N_STEPS - 1));

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= CODE_NONE;
      err_step_q  <= '0;
      seq_count_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
      err_step_q  <= err_step_d;
      seq_count_q <= seq_count_d;
    end
  end

  // Next-state logic: classify the sampled bus against the current step.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    err_d        = err_q;
    code_d       = code_q;
    err_step_d   = err_step_q;
    seq_count_d  = seq_count_q;
    err_hit      = 1'b0;
    err_hit_code = CODE_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (i_pulse_bus == onehot_first) begin
            state_d = ST_MEASURE;
            step_d  = '0;
            cnt_d   = NB_CNT'(1);
          end else if (i_pulse_bus != '0) begin
            err_hit      = 1'b1;
            err_hit_code = CODE_ORDER;
          end
        end
      end

      ST_MEASURE: begin
        if (i_valid) begin
          if (i_pulse_bus == onehot_cur) begin
            cnt_d = cnt_inc;
            if (cnt_inc > cur_len) begin
              err_hit      = 1'b1;
              err_hit_code = CODE_LONG;
            end
          end else if (!step_last && i_pulse_bus == onehot_next) begin
            if (cnt_q == cur_len) begin
              step_d = step_q + LOG2_N_STEPS'(1);
              cnt_d  = NB_CNT'(1);
            end else begin
              err_hit      = 1'b1;
              err_hit_code = CODE_SHORT;
            end
          end else if (step_last && i_pulse_bus == '0) begin
            if (cnt_q == cur_len) begin
              state_d = ST_IDLE;
              step_d  = '0;
              cnt_d   = '0;
              done_d  = 1'b1;
              if (!(&seq_count_q)) begin
                seq_count_d = seq_count_q + NB_SEQ_COUNT'(1);
              end
            end else begin
              err_hit      = 1'b1;
              err_hit_code = CODE_SHORT;
            end
          end else begin
            err_hit      = 1'b1;
            err_hit_code = CODE_ORDER;
          end
        end
      end

      ST_ERROR: begin
        state_d = ST_ERROR;
      end

      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
        cnt_d   = '0;
      end
    endcase

    // Only reachable outside ERROR, so the first recorded error is never overwritten.
    if (err_hit) begin
      state_d    = ST_ERROR;
      err_d      = 1'b1;
      code_d     = err_hit_code;
      err_step_d = step_q;
    end

    if (i_clear) begin
      state_d     = ST_IDLE;
      step_d      = '0;
      cnt_d       = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      code_d      = CODE_NONE;
      err_step_d  = '0;
      seq_count_d = '0;
    end
  end

  // Output logic: every output is a register image.
  always_comb begin
    o_state      = state_q;
    o_done       = done_q;
    o_error      = err_q;
    o_error_code = code_q;
    o_error_step = err_step_q;
    o_seq_count  = seq_count_q;
  end

  a_state_legal: assert property (@(posedge i_clock) disable iff (i_reset)
    state_q != ST_ILLEGAL);

  a_done_excl: assert property (@(posedge i_clock) disable iff (i_reset)
    !(done_q && err_q));

endmodule

// File: tb/tb_pulse_sequence_checker_fsm.sv
// Bench for pulse_sequence_checker_fsm: sequences described by per-step durations, outcome
// predicted from those durations, monitor compares every done/error event against a queue.
module tb_pulse_sequence_checker_fsm;

  localparam int NB_STATE     = 2;
  localparam int N_STEPS      = 5;
  localparam int LOG2_N_STEPS = 3;
  localparam int NB_TIMER     = 4;
  localparam int NB_SEQ_COUNT = 8;
  localparam int EXP_W        = 1 + 2 + LOG2_N_STEPS + NB_SEQ_COUNT;
  localparam int SEQ_MAX      = (1 << NB_SEQ_COUNT) - 1;

  logic                        i_clock = 1'b0;
  logic                        i_reset;
  logic                        i_valid;
  logic [N_STEPS-1:0]          i_pulse_bus;
  logic [N_STEPS*NB_TIMER-1:0] i_limit_time_bus;
  logic                        i_clear;
  logic                        o_done;
  logic                        o_error;
  logic [1:0]                  o_error_code;
  logic [LOG2_N_STEPS-1:0]     o_error_step;
  logic [NB_SEQ_COUNT-1:0]     o_seq_count;
  logic [NB_STATE-1:0]         o_state;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int lim [N_STEPS];
  int model_count = 0;
  bit gaps_en = 1'b0;
  logic err_prev = 1'b0;

  pulse_sequence_checker_fsm #(
    .NB_STATE(NB_STATE), .N_STEPS(N_STEPS), .LOG2_N_STEPS(LOG2_N_STEPS),
    .NB_TIMER(NB_TIMER), .NB_SEQ_COUNT(NB_SEQ_COUNT)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_pulse_bus(i_pulse_bus), .i_limit_time_bus(i_limit_time_bus), .i_clear(i_clear),
    .o_done(o_done), .o_error(o_error), .o_error_code(o_error_code),
    .o_error_step(o_error_step), .o_seq_count(o_seq_count), .o_state(o_state)
  );

  // Clock / watchdog.
  always #5 i_clock = ~i_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack(input bit dn, input int code, input int step,
                                             input int cnt);
    return {dn, 2'(code), LOG2_N_STEPS'(step), NB_SEQ_COUNT'(cnt)};
  endfunction

  function automatic int len(input int k);
    return (lim[k] == 0) ? (1 << NB_TIMER) : lim[k];
  endfunction

  // Monitor: every done pulse or new error must match the head of the queue.
  always @(negedge i_clock) begin
    if (!i_reset && (o_done || (o_error && !err_prev))) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL event: actual unexpected done=%0b code=%0d step=%0d count=%0d, required none",
                 o_done, o_error_code, o_error_step, o_seq_count);
      end else begin
        check("event", 32'(pack(o_done, o_error_code, o_error_step, o_seq_count)),
              32'(exp_q.pop_front()));
      end
    end
    err_prev <= o_error;
  end

  // Driver tasks: each call spans one clock and returns on the falling edge.
  task automatic tick(input logic v, input logic [N_STEPS-1:0] bus, input logic clr);
    i_valid     = v;
    i_pulse_bus = bus;
    i_clear     = clr;
    @(negedge i_clock);
  endtask

  task automatic valid_cycle(input logic [N_STEPS-1:0] bus);
    if (gaps_en && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) tick(1'b0, N_STEPS'($urandom), 1'b0);
    end
    tick(1'b1, bus, 1'b0);
  endtask

  task automatic set_limits(input int l0, input int l1, input int l2, input int l3, input int l4);
    lim[0] = l0; lim[1] = l1; lim[2] = l2; lim[3] = l3; lim[4] = l4;
    for (int k = 0; k < N_STEPS; k++) i_limit_time_bus[k*NB_TIMER +: NB_TIMER] = NB_TIMER'(lim[k]);
  endtask

  // Reference model: outcome from step durations plus an optional corrupted cycle.
  task automatic run_seq(input int d [N_STEPS], input int bad_pos,
                         input logic [N_STEPS-1:0] bad_bus, output bit had_err);
    logic [N_STEPS-1:0] seq[$];
    int start [N_STEPS];
    int total = 0;
    int e_idx = -1;
    int e_code = 0;
    int e_step = 0;
    for (int k = 0; k < N_STEPS; k++) begin
      start[k] = total;
      repeat (d[k]) seq.push_back(N_STEPS'(1) << k);
      total += d[k];
    end
    seq.push_back('0);
    for (int k = 0; k < N_STEPS; k++) begin
      if (d[k] != len(k)) begin
        e_code = (d[k] > len(k)) ? 3 : 2;
        e_idx  = (d[k] > len(k)) ? start[k] + len(k) : start[k] + d[k];
        e_step = k;
        break;
      end
    end
    if (bad_pos >= 0 && (e_idx < 0 || bad_pos <= e_idx)) begin
      seq[bad_pos] = bad_bus;
      e_idx  = bad_pos;
      e_code = 1;
      e_step = 0;
      for (int k = 0; k < N_STEPS; k++)
        if (bad_pos > 0 && bad_pos - 1 >= start[k] && bad_pos - 1 < start[k] + d[k]) e_step = k;
    end
    if (e_idx >= 0) begin
      exp_q.push_back(pack(1'b0, e_code, e_step, model_count));
    end else begin
      if (model_count < SEQ_MAX) model_count++;
      exp_q.push_back(pack(1'b1, 0, 0, model_count));
    end
    had_err = (e_idx >= 0);
    foreach (seq[i]) valid_cycle(seq[i]);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge i_clock);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_and_check();
    tick(1'($urandom_range(0, 1)), '0, 1'b1);
    model_count = 0;
    check("clear_error", 32'(o_error), 32'd0);
    check("clear_code", 32'(o_error_code), 32'd0);
    check("clear_step", 32'(o_error_step), 32'd0);
    check("clear_count", 32'(o_seq_count), 32'd0);
    check("clear_state", 32'(o_state), 32'd0);
    tick(1'b0, '0, 1'b0);
  endtask

  task automatic error_case(input int d [N_STEPS], input int bad_pos,
                            input logic [N_STEPS-1:0] bad_bus);
    bit had_err;
    run_seq(d, bad_pos, bad_bus, had_err);
    drain();
    if (had_err) begin
      check("sticky_error", 32'(o_error), 32'd1);
      check("sticky_state", 32'(o_state), 32'd2);
      clear_and_check();
    end
  endtask

  // Main stimulus.
  initial begin
    bit had_err;
    int d [N_STEPS];
    int bad;
    logic [N_STEPS-1:0] bb;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_pulse_bus = '0;
    i_clear = 1'b0;
    set_limits(1, 2, 3, 4, 5);
    repeat (2) @(negedge i_clock);
    check("reset_outputs", 32'(pack(o_done, o_error_code, o_error_step, o_seq_count)), 32'd0);
    check("reset_error_state", 32'({o_error, o_state}), 32'd0);
    i_reset = 1'b0;
    tick(1'b0, '0, 1'b0);

    // Nominal sequence: done exactly one clock after the zero cycle.
    run_seq('{1, 2, 3, 4, 5}, -1, '0, had_err);
    check("done_latency", 32'(o_done), 32'd1);
    tick(1'b0, '0, 1'b0);
    check("done_one_clock", 32'(o_done), 32'd0);
    check("nominal_count", 32'(o_seq_count), 32'd1);
    check("nominal_error", 32'(o_error), 32'd0);
    drain();

    error_case('{1, 2, 2, 4, 5}, -1, '0);
    error_case('{1, 2, 3, 4, 6}, -1, '0);
    error_case('{1, 2, 3, 4, 5}, 0, 5'b00100);
    error_case('{1, 2, 3, 4, 5}, 1, 5'b00011);

    set_limits(1, 0, 3, 4, 5);
    error_case('{1, 16, 3, 4, 5}, -1, '0);
    error_case('{1, 17, 3, 4, 5}, -1, '0);
    gaps_en = 1'b1;
    error_case('{1, 16, 3, 4, 5}, -1, '0);
    error_case('{1, 17, 3, 4, 5}, -1, '0);
    error_case('{1, 2, 2, 4, 5}, -1, '0);

    // Randomized limits, durations, gaps and corruption.
    for (int n = 0; n < 40; n++) begin
      set_limits($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      for (int k = 0; k < N_STEPS; k++) begin
        int r = $urandom_range(0, 9);
        d[k] = len(k);
        if (r == 0 && d[k] > 1) d[k] = d[k] - 1;
        else if (r == 1) d[k] = d[k] + 1;
      end
      bad = -1;
      bb = '0;
      if ($urandom_range(0, 4) == 0) begin
        int a = $urandom_range(0, N_STEPS - 1);
        int b = (a + $urandom_range(1, N_STEPS - 1)) % N_STEPS;
        bb[a] = 1'b1;
        bb[b] = 1'b1;
        bad = $urandom_range(0, d[0] + d[1] + d[2] + d[3] + d[4]);
      end
      error_case(d, bad, bb);
    end
    clear_and_check();

    // Five back-to-back sequences separated by a single zero cycle.
    gaps_en = 1'b0;
    set_limits(1, 2, 3, 4, 5);
    repeat (5) run_seq('{1, 2, 3, 4, 5}, -1, '0, had_err);
    drain();
    check("b2b_count", 32'(o_seq_count), 32'd5);

    // Reset in the middle of step 3: asynchronous, silent abort.
    valid_cycle(5'b00001);
    repeat (2) valid_cycle(5'b00010);
    repeat (3) valid_cycle(5'b00100);
    repeat (2) valid_cycle(5'b01000);
    #2 i_reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(pack(o_done, o_error_code, o_error_step, o_seq_count)), 32'd0);
    check("async_reset_state", 32'({o_error, o_state}), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b0;
    model_count = 0;
    tick(1'b0, '0, 1'b0);
    run_seq('{1, 2, 3, 4, 5}, -1, '0, had_err);
    drain();

    // Clear in the completion cycle wins over the completion.
    valid_cycle(5'b00001);
    repeat (2) valid_cycle(5'b00010);
    repeat (3) valid_cycle(5'b00100);
    repeat (4) valid_cycle(5'b01000);
    repeat (5) valid_cycle(5'b10000);
    tick(1'b1, '0, 1'b1);
    model_count = 0;
    check("clear_wins_count", 32'(o_seq_count), 32'd0);
    check("clear_wins_done", 32'(o_done), 32'd0);
    check("clear_wins_state", 32'(o_state), 32'd0);
    tick(1'b0, '0, 1'b0);

    // Saturation of the good-sequence counter.
    set_limits(1, 1, 1, 1, 1);
    repeat (SEQ_MAX + 4) run_seq('{1, 1, 1, 1, 1}, -1, '0, had_err);
    drain();
    check("seq_count_saturated", 32'(o_seq_count), 32'(SEQ_MAX));

    repeat (3) tick(1'b0, '0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
